// File: rtl/hbridge_pwm_dt_if.sv
// Control-side and gate-side signals of the H-bridge PWM block.
// master = control loop / stimulus side, slave = the PWM block.
interface hbridge_pwm_dt_if #(
    parameter int WIDTH    = 10,
    parameter int DT_WIDTH = 6
);
    logic                i_enable;
    logic [WIDTH-1:0]    i_duty_cycle;
    logic [DT_WIDTH-1:0] i_dead_time;
    logic                i_fault;
    logic                i_fault_clear;
    logic                o_a_high;
    logic                o_a_low;
    logic                o_b_high;
    logic                o_b_low;
    logic                o_period_start;
    logic                o_fault_latched;

    modport master (
        output i_enable, i_duty_cycle, i_dead_time, i_fault, i_fault_clear,
        input  o_a_high, o_a_low, o_b_high, o_b_low, o_period_start, o_fault_latched
    );

    modport slave (
        input  i_enable, i_duty_cycle, i_dead_time, i_fault, i_fault_clear,
        output o_a_high, o_a_low, o_b_high, o_b_low, o_period_start, o_fault_latched
    );
endinterface

// File: rtl/hbridge_pwm_dt.sv
// Full H-bridge PWM with per-leg dead-time, period-boundary shadow registers and latched fault.
// Define CENTER_ALIGNED_EN for an up/down (center-aligned) counter; default is edge-aligned.
module hbridge_pwm_dt #(
    parameter int WIDTH    = 10,
    parameter int DT_WIDTH = 6
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    hbridge_pwm_dt_if.slave bus
);
    localparam logic [WIDTH-1:0]    CNT_MAX = '1;
    localparam logic [WIDTH-1:0]    CNT_ONE = WIDTH'(1);
    localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    duty_sh_q, duty_sh_d;
    logic [DT_WIDTH-1:0] dt_sh_q, dt_sh_d;
    logic                fault_q, fault_d;
    logic                period_start_q, period_start_d;
    logic                run_edge;
    logic                valley;
    logic                boundary;
    logic                cmd_a;

    // run_edge: the block keeps running across this edge (enabled, no latched or new fault)
    always_comb begin
        fault_d  = bus.i_fault | (fault_q & ~bus.i_fault_clear);
        run_edge = bus.i_enable & ~fault_q & ~bus.i_fault;
    end

`ifdef CENTER_ALIGNED_EN
    logic dir_up_q, dir_up_d;

    always_comb begin
        cnt_d    = '0;
        dir_up_d = 1'b1;
        if (run_edge) begin
            if (dir_up_q) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d    = cnt_q - CNT_ONE;
                    dir_up_d = 1'b0;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d    = cnt_q - CNT_ONE;
                dir_up_d = (cnt_q == CNT_ONE);
            end
        end
        valley   = (cnt_q == '0) && dir_up_q;
        boundary = (cnt_q == CNT_ONE) && !dir_up_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dir_up_q <= 1'b1;
        end else begin
            dir_up_q <= dir_up_d;
        end
    end
`else
    always_comb begin
        cnt_d    = run_edge ? (cnt_q + CNT_ONE) : '0;
        valley   = (cnt_q == '0);
        boundary = (cnt_q == CNT_MAX);
    end
`endif

    // Shadows follow the inputs while idle so a restart always uses the latest values
    always_comb begin
        duty_sh_d      = duty_sh_q;
        dt_sh_d        = dt_sh_q;
        period_start_d = run_edge & valley;
        if (!run_edge || boundary) begin
            duty_sh_d = bus.i_duty_cycle;
            dt_sh_d   = bus.i_dead_time;
        end
        cmd_a = (cnt_q < duty_sh_q);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q          <= '0;
            duty_sh_q      <= '0;
            dt_sh_q        <= '0;
            fault_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_sh_q      <= duty_sh_d;
            dt_sh_q        <= dt_sh_d;
            fault_q        <= fault_d;
            period_start_q <= period_start_d;
        end
    end

    // Leg 0 = A (follows cmd_a), leg 1 = B (complement).
    // off_q marks the all-off state so a restart is handled as a fresh transition.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_leg
            logic                cmd;
            logic                high_q, high_d;
            logic                low_q, low_d;
            logic                tgt_q, tgt_d;
            logic                off_q, off_d;
            logic [DT_WIDTH-1:0] dtc_q, dtc_d;

            assign cmd = (gi == 0) ? cmd_a : ~cmd_a;

            always_comb begin
                high_d = 1'b0;
                low_d  = 1'b0;
                tgt_d  = tgt_q;
                off_d  = off_q;
                dtc_d  = dtc_q;
                if (!run_edge) begin
                    off_d = 1'b1;
                    tgt_d = 1'b0;
                    dtc_d = '0;
                end else if (off_q || (cmd != tgt_q)) begin
                    // New target: the on gate drops now; a change mid dead-time restarts the gap
                    tgt_d = cmd;
                    off_d = 1'b0;
                    if (dt_sh_q == '0) begin
                        high_d = cmd;
                        low_d  = ~cmd;
                        dtc_d  = '0;
                    end else begin
                        dtc_d = dt_sh_q;
                    end
                end else if (dtc_q <= DT_ONE) begin
                    high_d = tgt_q;
                    low_d  = ~tgt_q;
                    dtc_d  = '0;
                end else begin
                    dtc_d = dtc_q - DT_ONE;
                end
            end

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    high_q <= 1'b0;
                    low_q  <= 1'b0;
                    tgt_q  <= 1'b0;
                    off_q  <= 1'b1;
                    dtc_q  <= '0;
                end else begin
                    high_q <= high_d;
                    low_q  <= low_d;
                    tgt_q  <= tgt_d;
                    off_q  <= off_d;
                    dtc_q  <= dtc_d;
                end
            end
        end
    endgenerate

    assign bus.o_a_high        = g_leg[0].high_q;
    assign bus.o_a_low         = g_leg[0].low_q;
    assign bus.o_b_high        = g_leg[1].high_q;
    assign bus.o_b_low         = g_leg[1].low_q;
    assign bus.o_period_start  = period_start_q;
    assign bus.o_fault_latched = fault_q;

endmodule

// File: tb/tb_hbridge_pwm_dt.sv
// Directed bench for hbridge_pwm_dt: per-period gate counts from a vector table,
// plus sequences for shadow update, fault latch/clear and asynchronous reset.
module tb_hbridge_pwm_dt;
    localparam int W   = 10;
    localparam int DTW = 6;
    localparam int N   = 1 << W;

    typedef struct {
        int duty;
        int dt;
        int a_hi;
        int a_lo;
        int b_hi;
        int b_lo;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    hbridge_pwm_dt_if #(.WIDTH(W), .DT_WIDTH(DTW)) bus ();

    hbridge_pwm_dt #(.WIDTH(W), .DT_WIDTH(DTW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always @(negedge clk) begin
        if ((bus.o_a_high && bus.o_a_low) || (bus.o_b_high && bus.o_b_low)) begin
            errors++;
            $display("FAIL shoot_through t=%0t actual a=%b%b b=%b%b required no leg with high&low",
                     $time, bus.o_a_high, bus.o_a_low, bus.o_b_high, bus.o_b_low);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.o_a_high, bus.o_a_low, bus.o_b_high, bus.o_b_low,
                     bus.o_period_start, bus.o_fault_latched});
    endfunction

    function automatic int gates();
        return int'({bus.o_a_high, bus.o_a_low, bus.o_b_high, bus.o_b_low});
    endfunction

    task automatic wait_ps(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.o_period_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.o_period_start), 1);
    endtask

    // Samples N cycles starting at the current negedge (expected to carry o_period_start)
    task automatic window(output int ah, output int al, output int bh, output int bl,
                          output int ps, output int fah, output int fal,
                          input int chg_at, input int chg_duty, input int chg_dt);
        ah = 0; al = 0; bh = 0; bl = 0; ps = 0; fah = -1; fal = -1;
        for (int i = 0; i < N; i++) begin
            ah += int'(bus.o_a_high);
            al += int'(bus.o_a_low);
            bh += int'(bus.o_b_high);
            bl += int'(bus.o_b_low);
            ps += int'(bus.o_period_start);
            if (bus.o_a_high && fah < 0) fah = i;
            if (bus.o_a_low && fah >= 0 && fal < 0) fal = i;
            if (i == chg_at) begin
                bus.i_duty_cycle = W'(chg_duty);
                bus.i_dead_time  = DTW'(chg_dt);
            end
            @(negedge clk);
        end
        $display("window a_hi=%0d a_lo=%0d b_hi=%0d b_lo=%0d ps=%0d first_ahi=%0d first_alo=%0d",
                 ah, al, bh, bl, ps, fah, fal);
    endtask

    // Disable, load new settings, enable, and stop at the start of the second period
    task automatic setup(input int duty, input int dt, input string name);
        bus.i_enable     = 1'b0;
        bus.i_duty_cycle = W'(duty);
        bus.i_dead_time  = DTW'(dt);
        @(negedge clk);
        chk({name, "_disabled_gates"}, gates(), 0);
        @(negedge clk);
        bus.i_enable = 1'b1;
        wait_ps({name, "_ps1"});
        wait_ps({name, "_ps2"});
    endtask

    initial begin
        int ah, al, bh, bl, ps, fah, fal;

        bus.i_enable      = 1'b0;
        bus.i_duty_cycle  = '0;
        bus.i_dead_time   = '0;
        bus.i_fault       = 1'b0;
        bus.i_fault_clear = 1'b0;

        vecs[0] = '{512,  0, 512,  512,  512,  512};
        vecs[1] = '{500,  5, 495,  519,  519,  495};
        vecs[2] = '{0,    0, 0,    1024, 1024, 0};
        vecs[3] = '{0,    7, 0,    1024, 1024, 0};
        vecs[4] = '{1023, 0, 1023, 1,    1,    1023};
        vecs[5] = '{10,  20, 0,    994,  994,  0};
        vecs[6] = '{1023, 5, 1018, 0,    0,    1018};
        vecs[7] = '{1,    0, 1,    1023, 1023, 1};
        vecs[8] = '{300, 63, 237,  661,  661,  237};
        vecs[9] = '{6,    6, 0,    1012, 1012, 0};

        #12;
        chk("reset_outputs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", outs(), 0);

        for (int v = 0; v < 10; v++) begin
            setup(vecs[v].duty, vecs[v].dt, $sformatf("vec%0d", v));
            window(ah, al, bh, bl, ps, fah, fal, -1, 0, 0);
            chk($sformatf("vec%0d_a_high", v), ah, vecs[v].a_hi);
            chk($sformatf("vec%0d_a_low", v),  al, vecs[v].a_lo);
            chk($sformatf("vec%0d_b_high", v), bh, vecs[v].b_hi);
            chk($sformatf("vec%0d_b_low", v),  bl, vecs[v].b_lo);
            chk($sformatf("vec%0d_ps_in_window", v), ps, 1);
            chk($sformatf("vec%0d_ps_next", v), int'(bus.o_period_start), 1);
        end

        // Mid-period change: current period keeps 500/5, next shows 15/2
        setup(500, 5, "shadow");
        window(ah, al, bh, bl, ps, fah, fal, 100, 15, 2);
        chk("shadow_cur_a_high", ah, 495);
        chk("shadow_cur_a_low", al, 519);
        chk("shadow_cur_gap_start", fah, 5);
        chk("shadow_cur_gap_end", fal, 505);
        chk("shadow_ps_next", int'(bus.o_period_start), 1);
        window(ah, al, bh, bl, ps, fah, fal, -1, 0, 0);
        chk("shadow_new_a_high", ah, 13);
        chk("shadow_new_a_low", al, 1007);
        chk("shadow_new_b_high", bh, 1007);
        chk("shadow_new_b_low", bl, 13);
        chk("shadow_new_first_ahi", fah, 2);
        chk("shadow_new_first_alo", fal, 17);

        // Fault latch, ignored clear while fault held, then clear and restart
        setup(500, 5, "fault");
        repeat (300) @(negedge clk);
        bus.i_fault = 1'b1;
        @(negedge clk);
        chk("fault_gates_off", gates(), 0);
        chk("fault_latched", int'(bus.o_fault_latched), 1);
        bus.i_fault_clear = 1'b1;
        repeat (3) @(negedge clk);
        chk("fault_clear_blocked", int'(bus.o_fault_latched), 1);
        chk("fault_hold_gates", gates(), 0);
        chk("fault_hold_ps", int'(bus.o_period_start), 0);
        bus.i_fault = 1'b0;
        @(negedge clk);
        chk("fault_cleared", int'(bus.o_fault_latched), 0);
        chk("fault_clear_gates", gates(), 0);
        bus.i_fault_clear = 1'b0;
        @(negedge clk);
        chk("restart_ps", int'(bus.o_period_start), 1);
        chk("restart_gates_off", gates(), 0);
        window(ah, al, bh, bl, ps, fah, fal, -1, 0, 0);
        chk("restart_first_ahi", fah, 5);
        chk("restart_first_alo", fal, 505);
        chk("restart_a_high", ah, 495);

        // Asynchronous reset between clock edges
        repeat (50) @(negedge clk);
        chk("pre_reset_a_high", int'(bus.o_a_high), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        bus.i_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_idle", outs(), 0);
        bus.i_enable = 1'b1;
        wait_ps("post_reset_ps");
        chk("post_reset_gates_off", gates(), 0);
        window(ah, al, bh, bl, ps, fah, fal, -1, 0, 0);
        chk("post_reset_first_ahi", fah, 5);
        chk("post_reset_first_alo", fal, 505);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
